// File: rtl/tm1638_keyscan_if.sv
// Shared TM1638 serial bus plus the request/grant handshake with the display driver.
// The key-read engine takes the master side; the arbiter/pad wrapper takes the slave side.
interface tm1638_keyscan_if;
  logic bus_req;
  logic bus_gnt;
  logic tm_stb;
  logic tm_clk;
  logic dio_out;
  logic dio_oe;
  logic dio_in;

  modport master (
    output bus_req, tm_stb, tm_clk, dio_out, dio_oe,
    input  bus_gnt, dio_in
  );

  modport slave (
    input  bus_req, tm_stb, tm_clk, dio_out, dio_oe,
    output bus_gnt, dio_in
  );
endinterface

// File: rtl/tm1638_keyscan.sv
// TM1638 key-read engine: periodic read-key command, 32-bit readback, key debounce and press pulses.
// Optional macro TM1638_KEYSCAN_DEBOUNCE_EN enables the stability counter; without it keys follow every scan.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | scan timer counting down, bus released
// S_REQ    | bus_req high, waiting for bus_gnt
// S_STB_LO | STB asserted, one cycle before the first command bit
// S_CMD    | shifting out 0x42 LSB-first, two cycles per bit
// S_WAIT   | DIO released, Twait gap before the read clocks
// S_READ   | clocking in 32 bits LSB-first, two cycles per bit
// S_STB_HI | STB released, raw vector evaluated and keys updated
module tm1638_keyscan #(
  parameter int SCAN_DIV = 50,
  parameter int WAIT_CYC = 2,
  parameter int DEBOUNCE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  tm1638_keyscan_if.master     bus,
  output logic [7:0]           keys,
  output logic [7:0]           key_press,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_STB_LO, S_CMD, S_WAIT, S_READ, S_STB_HI
  } state_t;

  localparam logic [7:0]  CMD_READ    = 8'h42;
  localparam logic [15:0] SCAN_RELOAD = 16'(SCAN_DIV - 1);
  localparam logic [15:0] WAIT_RELOAD = 16'(WAIT_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic        capture;

  logic        stb_q, stb_d;
  logic        tclk_q, tclk_d;
  logic        dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        req_q, req_d;

  logic [7:0]  raw_sh_q;
  logic [7:0]  keys_q, keys_d;
  logic [7:0]  press_q, press_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cnt_q == 16'd0) state_d = S_REQ;
        else                cnt_d   = cnt_q - 16'd1;
      end
      S_REQ: begin
        if (bus.bus_gnt) state_d = S_STB_LO;
      end
      S_STB_LO: begin
        state_d = S_CMD;
        bit_d   = 5'd0;
        phase_d = 1'b0;
      end
      S_CMD: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (bit_q == 5'd7) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_RELOAD;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 16'd0) begin
          state_d = S_READ;
          bit_d   = 5'd0;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_READ: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          capture = 1'b1;
          if (bit_q == 5'd31) state_d = S_STB_HI;
          else                bit_d   = bit_q + 5'd1;
        end
      end
      S_STB_HI: begin
        state_d = S_IDLE;
        cnt_d   = SCAN_RELOAD;
      end
      default: state_d = S_IDLE;
    endcase

    // Pin values are decoded from the next state so every bus output is a plain flop.
    stb_d  = 1'b1;
    tclk_d = 1'b1;
    dout_d = 1'b1;
    oe_d   = 1'b0;
    case (state_d)
      S_STB_LO: begin
        stb_d = 1'b0;
        oe_d  = 1'b1;
      end
      S_CMD: begin
        stb_d  = 1'b0;
        oe_d   = 1'b1;
        tclk_d = phase_d;
        dout_d = CMD_READ[bit_d[2:0]];
      end
      S_WAIT: stb_d = 1'b0;
      S_READ: begin
        stb_d  = 1'b0;
        tclk_d = phase_d;
      end
      default: ;
    endcase
    req_d = (state_d != S_IDLE);
  end

`ifdef TM1638_KEYSCAN_DEBOUNCE_EN
  localparam logic [3:0] DB_THR = 4'(DEBOUNCE);

  logic [3:0] stab_q, stab_d;
  logic [7:0] raw_prev_q;

  always_comb begin
    stab_d = stab_q;
    keys_d = keys_q;
    if (state_q == S_STB_HI) begin
      if (raw_sh_q == raw_prev_q) stab_d = (stab_q == 4'hF) ? stab_q : stab_q + 4'd1;
      else                        stab_d = 4'd1;
      if (stab_d >= DB_THR) keys_d = raw_sh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stab_q     <= 4'd0;
      raw_prev_q <= 8'h00;
    end else if (state_q == S_STB_HI) begin
      stab_q     <= stab_d;
      raw_prev_q <= raw_sh_q;
    end
  end
`else
  logic [3:0] unused_debounce;
  assign unused_debounce = 4'(DEBOUNCE);

  always_comb begin
    keys_d = keys_q;
    if (state_q == S_STB_HI) keys_d = raw_sh_q;
  end
`endif

  always_comb begin
    press_d = 8'h00;
    if (state_q == S_STB_HI) press_d = keys_d & ~keys_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= SCAN_RELOAD;
      bit_q    <= 5'd0;
      phase_q  <= 1'b0;
      stb_q    <= 1'b1;
      tclk_q   <= 1'b1;
      dout_q   <= 1'b1;
      oe_q     <= 1'b0;
      req_q    <= 1'b0;
      raw_sh_q <= 8'h00;
      keys_q   <= 8'h00;
      press_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      stb_q   <= stb_d;
      tclk_q  <= tclk_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      req_q   <= req_d;
      keys_q  <= keys_d;
      press_q <= press_d;
      // Only bit0 and bit4 of each scan byte carry a key: raw[2i] = byte i bit0, raw[2i+1] = bit4.
      if (capture && (bit_q[1:0] == 2'b00)) raw_sh_q[{bit_q[4:3], bit_q[2]}] <= bus.dio_in;
    end
  end

  assign bus.bus_req = req_q;
  assign bus.tm_stb  = stb_q;
  assign bus.tm_clk  = tclk_q;
  assign bus.dio_out = dout_q;
  assign bus.dio_oe  = oe_q;
  assign busy        = req_q;
  assign keys        = keys_q;
  assign key_press   = press_q;

endmodule
